// File: rtl/pwm_hbridge.sv
// Sign-magnitude PWM generator for an H-bridge, fed by a signed PID command.
// The command is sampled once per period; direction reversals insert a both-low dead-time.
module pwm_hbridge #(
  parameter int unsigned PERIOD      = 1000,
  parameter int unsigned DEAD_CYCLES = 50,
  parameter int unsigned SHIFT       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [15:0] command,
  output logic               pwm_a,
  output logic               pwm_b,
  output logic               dir,
  output logic [15:0]        duty,
  output logic               period_start
);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [15:0] PERIOD_M1 = 16'(PERIOD - 1);
  localparam logic [15:0] DEAD_M1   = 16'(DEAD_CYCLES - 1);
  localparam logic [16:0] PERIOD_17 = 17'(PERIOD);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] dcnt_reg, dcnt_next;
  logic [15:0] duty_reg, duty_next;
  logic        dir_reg, dir_next;

  // Magnitude is formed in 17 bits so that -32768 maps to +32768.
  logic [16:0] cmd_ext;
  logic [16:0] abs_val;
  logic [16:0] shifted;
  logic [15:0] mag;
  logic        sgn;

  always_comb begin
    cmd_ext = {command[15], command};
    abs_val = command[15] ? (17'd0 - cmd_ext) : cmd_ext;
    shifted = abs_val >> SHIFT;
    mag     = (shifted > PERIOD_17) ? PERIOD_17[15:0] : shifted[15:0];
    sgn     = command[15];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      dcnt_reg  <= 16'd0;
      duty_reg  <= 16'd0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dcnt_reg  <= dcnt_next;
      duty_reg  <= duty_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dcnt_next  = dcnt_reg;
    duty_next  = duty_reg;
    dir_next   = dir_reg;

    if (!enable) begin
      // Bridge off: counters and duty clear, direction is remembered.
      state_next = IDLE;
      cnt_next   = 16'd0;
      dcnt_next  = 16'd0;
      duty_next  = 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Bridge is already off, so a direction change needs no dead-time here.
          state_next = RUN;
          cnt_next   = 16'd0;
          duty_next  = mag;
          if (mag != 16'd0) dir_next = sgn;
        end
        RUN: begin
          if (cnt_reg == PERIOD_M1) begin
            duty_next = mag;
            if ((mag != 16'd0) && (sgn != dir_reg)) begin
              state_next = DEAD;
              dir_next   = sgn;
              dcnt_next  = 16'd0;
            end else begin
              cnt_next = 16'd0;
            end
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        DEAD: begin
          if (dcnt_reg == DEAD_M1) begin
            state_next = RUN;
            cnt_next   = 16'd0;
          end else begin
            dcnt_next = dcnt_reg + 16'd1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  logic active;
  assign active       = (state_reg == RUN) && (cnt_reg < duty_reg);
  assign pwm_a        = active & ~dir_reg;
  assign pwm_b        = active & dir_reg;
  assign period_start = (state_reg == RUN) && (cnt_reg == 16'd0);
  assign dir          = dir_reg;
  assign duty         = duty_reg;

endmodule

// File: tb/tb_pwm_hbridge.sv
// Directed bench for pwm_hbridge with default parameters (PERIOD 1000, DEAD 50, SHIFT 5).
module tb_pwm_hbridge;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] command;
  logic               pwm_a, pwm_b, dir, period_start;
  logic [15:0]        duty;

  int tests_run = 0;
  int tests_failed = 0;

  pwm_hbridge dut (
    .clk(clk), .rst(rst), .enable(enable), .command(command),
    .pwm_a(pwm_a), .pwm_b(pwm_b), .dir(dir), .duty(duty),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // The two bridge inputs must never be high together.
  always @(negedge clk) check_eq("excl", {31'd0, pwm_a & pwm_b}, 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample n consecutive cycles starting with the current one.
  task automatic measure(input int n, output int na, output int nb, output int ns);
    na = 0; nb = 0; ns = 0;
    for (int i = 0; i < n; i++) begin
      na += int'(pwm_a);
      nb += int'(pwm_b);
      ns += int'(period_start);
      tick();
    end
  endtask

  int na, nb, ns;

  initial begin
    rst = 1'b1; enable = 1'b0; command = 16'sd0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_pwm_a", {31'd0, pwm_a}, 0);
    check_eq("rst_pwm_b", {31'd0, pwm_b}, 0);
    check_eq("rst_ps", {31'd0, period_start}, 0);
    check_eq("rst_duty", {16'd0, duty}, 0);
    check_eq("rst_dir", {31'd0, dir}, 0);

    // Forward half duty
    enable = 1'b1; command = 16'sd16000;
    tick();
    check_eq("fwd_duty", {16'd0, duty}, 500);
    check_eq("fwd_ps0", {31'd0, period_start}, 1);
    measure(1000, na, nb, ns);
    check_eq("fwd_a_cnt", na, 500);
    check_eq("fwd_b_cnt", nb, 0);
    check_eq("fwd_ps_cnt", ns, 1);
    check_eq("fwd_ps_next", {31'd0, period_start}, 1);

    // Full reverse from IDLE, -32768 clamps to PERIOD
    enable = 1'b0; tick();
    check_eq("off_duty", {16'd0, duty}, 0);
    command = -16'sd32768; enable = 1'b1; tick();
    check_eq("rev_dir", {31'd0, dir}, 1);
    check_eq("rev_duty", {16'd0, duty}, 1000);
    measure(1000, na, nb, ns);
    check_eq("rev_b_cnt", nb, 1000);
    check_eq("rev_a_cnt", na, 0);

    // Full forward from IDLE, 32767 clamps from 1023
    enable = 1'b0; tick();
    command = 16'sd32767; enable = 1'b1; tick();
    check_eq("max_dir", {31'd0, dir}, 0);
    check_eq("max_duty", {16'd0, duty}, 1000);
    command = 16'sd16000;
    measure(1000, na, nb, ns);
    check_eq("max_a_cnt", na, 1000);

    // Reversal with dead-time
    check_eq("pre_rev_duty", {16'd0, duty}, 500);
    measure(300, na, nb, ns);
    check_eq("pre_rev_a300", na, 300);
    command = -16'sd8000;
    measure(700, na, nb, ns);
    check_eq("old_period_a", na, 200);
    check_eq("old_period_b", nb, 0);
    check_eq("dead_dir", {31'd0, dir}, 1);
    check_eq("dead_duty", {16'd0, duty}, 250);
    measure(50, na, nb, ns);
    check_eq("dead_a", na, 0);
    check_eq("dead_b", nb, 0);
    check_eq("dead_ps", ns, 0);
    check_eq("post_dead_ps", {31'd0, period_start}, 1);
    check_eq("post_dead_b", {31'd0, pwm_b}, 1);
    measure(1000, na, nb, ns);
    check_eq("new_b_cnt", nb, 250);
    check_eq("new_a_cnt", na, 0);
    check_eq("new_ps_cnt", ns, 1);

    // Zero magnitude never triggers dead-time
    enable = 1'b0; tick();
    command = 16'sd3200; enable = 1'b1; tick();
    check_eq("z_dir0", {31'd0, dir}, 0);
    command = 16'sd31;
    measure(1000, na, nb, ns);
    check_eq("z_first_a", na, 100);
    check_eq("z_duty", {16'd0, duty}, 0);
    check_eq("z_ps", {31'd0, period_start}, 1);
    command = 16'sd3200;
    measure(1000, na, nb, ns);
    check_eq("z_a", na, 0);
    check_eq("z_b", nb, 0);
    check_eq("z_ps_cnt", ns, 1);
    check_eq("resume_dir", {31'd0, dir}, 0);
    check_eq("resume_duty", {16'd0, duty}, 100);
    check_eq("resume_ps", {31'd0, period_start}, 1);
    check_eq("resume_a", {31'd0, pwm_a}, 1);
    measure(1000, na, nb, ns);
    check_eq("resume_a_cnt", na, 100);

    // Enable dropped mid-period, re-enabled in reverse
    measure(300, na, nb, ns);
    enable = 1'b0; tick();
    check_eq("dis_a", {31'd0, pwm_a}, 0);
    check_eq("dis_ps", {31'd0, period_start}, 0);
    check_eq("dis_duty", {16'd0, duty}, 0);
    command = -16'sd3200; enable = 1'b1; tick();
    check_eq("reen_dir", {31'd0, dir}, 1);
    check_eq("reen_b", {31'd0, pwm_b}, 1);
    check_eq("reen_ps", {31'd0, period_start}, 1);
    command = 16'sd3200;
    measure(1000, na, nb, ns);
    check_eq("reen_b_cnt", nb, 100);
    check_eq("reen_a_cnt", na, 0);

    // Reset during dead-time at dcnt 20
    measure(20, na, nb, ns);
    check_eq("dead2_a", na, 0);
    check_eq("dead2_b", nb, 0);
    rst = 1'b1; tick();
    check_eq("rstd_dir", {31'd0, dir}, 0);
    check_eq("rstd_duty", {16'd0, duty}, 0);
    check_eq("rstd_a", {31'd0, pwm_a}, 0);
    check_eq("rstd_b", {31'd0, pwm_b}, 0);
    check_eq("rstd_ps", {31'd0, period_start}, 0);
    rst = 1'b0; tick();
    check_eq("after_rst_ps", {31'd0, period_start}, 1);
    check_eq("after_rst_a", {31'd0, pwm_a}, 1);
    check_eq("after_rst_duty", {16'd0, duty}, 100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
